seg_to_bin_decoder: RTL
=======================

SEG_TO_BIN_DECODER -- requirements
Module: seg_to_bin_decoder

Interface
REQ-001 Parameter STABLE_CYCLES, default 4: consecutive identical input samples required before a code is accepted; legal range 2..255.
REQ-002 clk  input  1  single global clock; all state is updated on the rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 seg1  input  7  tens-digit segment code, order {g,f,e,d,c,b,a}, active-low (0 = segment lit).
REQ-005 seg2  input  7  units-digit segment code, same order and polarity as seg1.
REQ-006 out_ready  input  1  consumer accepts the presented value.
REQ-007 value  output  7  decoded binary value, 0..99.
REQ-008 out_valid  output  1  value is held and pending acceptance.
REQ-009 error  output  1  the last stable code contained an invalid pattern.
REQ-010 overrun  output  1  sticky flag: a new value was lost while one was pending.
REQ-011 finished  output  1  the accepted value equals 15 (see Configuration).

Function
REQ-012 Inputs SHALL pass through a 2-flop synchronizer; all decoding uses the synchronized copy.
REQ-013 Digit table (active-low): 0=7'h40, 1=7'h79, 2=7'h24, 3=7'h30, 4=7'h19, 5=7'h12, 6=7'h02, 7=7'h78, 8=7'h00, 9=7'h10.
REQ-014 A seg1 of 7'h7F (blank) SHALL decode as tens = 0; a blank seg2, or any pattern not in the table on either digit, is invalid.
REQ-015 Decoding arithmetic: value = tens*10 + units, computed at 7-bit width with no truncation (maximum 99).
REQ-016 FSM states: IDLE, SETTLE, PRESENT.
REQ-017 IDLE -> SETTLE when the synchronized code differs from the last accepted code; the stability counter is cleared on entry.
REQ-018 SETTLE: the counter increments each cycle the code is unchanged and clears to 0 on any change.
REQ-019 SETTLE -> PRESENT when the counter reaches STABLE_CYCLES-1; the code is latched as the last accepted code in the same cycle.
REQ-020 Valid code on SETTLE exit: value is loaded, error cleared, and out_valid is set 1 cycle later (PRESENT).
REQ-021 Invalid code on SETTLE exit: error is set, value is held, out_valid stays 0, and the FSM returns to IDLE.
REQ-022 PRESENT: value and out_valid are held stable until out_valid && out_ready; after that handshake cycle the FSM goes to IDLE and out_valid is 0.
REQ-023 Overrun: the input is still monitored in PRESENT; if a different code completes settling before acceptance, overrun is set, the new code is discarded, and the held value is unchanged.
REQ-024 overrun SHALL clear only on reset.
REQ-025 Simultaneous events: acceptance in the same cycle that a new code completes settling is not an overrun; the new code is presented next, with out_valid 0 for exactly 1 cycle in between.
REQ-026 An identical code re-appearing after a glitch shorter than STABLE_CYCLES SHALL produce no new output.
REQ-027 Latency: output appears 2 (synchronizer) + STABLE_CYCLES + 1 cycles after the input change.

Reset
REQ-028 While rst=0: value=0, out_valid=0, error=0, overrun=0, finished=0, FSM=IDLE, counter=0.
REQ-029 Reset also sets the synchronizer flops and the last accepted code to 7'h7F/7'h40 (decoded 0), so a displayed "0" after reset produces no output.
REQ-030 Reset assertion mid-operation SHALL abort any pending handshake immediately (asynchronously); operation resumes on the first clk edge after release.

Configuration
REQ-031 Macro SEG2BIN_FINISH_EN defined: finished is registered, high while the last accepted valid value equals 15, and cleared when a different value is accepted.
REQ-032 Macro SEG2BIN_FINISH_EN undefined: finished is tied to 0 and no comparison logic is synthesized.

Verification
REQ-033 seg1=7'h79, seg2=7'h12 held, out_ready=1 -> value=15, out_valid pulses 1 cycle at cycle 7 (default STABLE_CYCLES); finished=1 when SEG2BIN_FINISH_EN is defined.
REQ-034 seg1=7'h7F, seg2=7'h10 -> value=9, error=0.
REQ-035 seg2=7'h7F or 7'h55 -> error=1, out_valid stays 0, value unchanged.
REQ-036 Code toggles 7'h24 <-> 7'h30 every 2 cycles for 40 cycles -> no out_valid; then held at 7'h30 -> exactly one output.
REQ-037 out_ready=0, value=42 pending, input changes to 57 and settles -> overrun=1, value stays 42; set out_ready=1 -> accepted, FSM returns to IDLE.
REQ-038 rst driven low while out_valid=1 -> all outputs 0 with no clock edge required.

Source files
------------

// File: rtl/seg_to_bin_decoder.sv
// Two-digit seven-segment (active-low) to binary decoder with input
// synchronization, stability filtering and a valid/ready output handshake.
// Optional feature: define SEG2BIN_FINISH_EN to register the "finished"
// flag (accepted value == 15); otherwise finished is tied low.
module seg_to_bin_decoder #(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] seg1,
  input  logic [6:0] seg2,
  input  logic       out_ready,
  output logic [6:0] value,
  output logic       out_valid,
  output logic       error,
  output logic       overrun,
  output logic       finished
);

  localparam int unsigned CW = 8;
  localparam int unsigned CODE_W = 14;
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);
  localparam logic [CODE_W-1:0] RST_CODE = {7'h7F, 7'h40};

  typedef enum logic [1:0] {IDLE, SETTLE, PRESENT} state_t;

  state_t            state, state_d;
  logic [CODE_W-1:0] sync_a, sync_b;
  logic [CODE_W-1:0] cand, cand_d;
  logic [CODE_W-1:0] last_code, last_d;
  logic [CW-1:0]     cnt, cnt_d;
  logic [6:0]        value_d;
  logic              error_d, overrun_d, load_c;
  logic [4:0]        tens_c, units_c;
  logic              cand_ok_c, settled_c;
  logic [6:0]        cand_val_c;

  // Segment pattern to {valid, digit}
  function automatic logic [4:0] dec_digit(input logic [6:0] s);
    logic [4:0] r;
    case (s)
      7'h40:   r = 5'h10;
      7'h79:   r = 5'h11;
      7'h24:   r = 5'h12;
      7'h30:   r = 5'h13;
      7'h19:   r = 5'h14;
      7'h12:   r = 5'h15;
      7'h02:   r = 5'h16;
      7'h78:   r = 5'h17;
      7'h00:   r = 5'h18;
      7'h10:   r = 5'h19;
      default: r = 5'h00;
    endcase
    return r;
  endfunction

  // Two-flop synchronizer on the combined code, reset to a displayed "0"
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_a <= RST_CODE;
      sync_b <= RST_CODE;
    end else begin
      sync_a <= {seg1, seg2};
      sync_b <= sync_a;
    end
  end

  // Decode of the candidate code; a blank tens digit reads as 0
  always_comb begin
    tens_c     = (cand[13:7] == 7'h7F) ? 5'h10 : dec_digit(cand[13:7]);
    units_c    = dec_digit(cand[6:0]);
    cand_ok_c  = tens_c[4] & units_c[4];
    cand_val_c = 7'(tens_c[3:0]) * 7'd10 + 7'(units_c[3:0]);
    settled_c  = (cnt == CNT_MAX) && (cand != last_code);
  end

  // Next-state and datapath control
  always_comb begin
    state_d   = state;
    cnt_d     = cnt;
    cand_d    = cand;
    last_d    = last_code;
    value_d   = value;
    error_d   = error;
    overrun_d = overrun;
    load_c    = 1'b0;
    case (state)
      IDLE: begin
        if (sync_b != last_code) begin
          state_d = SETTLE;
          cnt_d   = '0;
          cand_d  = sync_b;
        end
      end
      SETTLE: begin
        if (cnt == CNT_MAX) begin
          last_d = cand;
          if (cand == last_code) begin
            // glitch returned to the accepted code: nothing new to report
            state_d = IDLE;
          end else if (cand_ok_c) begin
            value_d = cand_val_c;
            error_d = 1'b0;
            load_c  = 1'b1;
            cnt_d   = '0;
            state_d = PRESENT;
          end else begin
            error_d = 1'b1;
            state_d = IDLE;
          end
        end else if (sync_b != cand) begin
          cand_d = sync_b;
          cnt_d  = '0;
        end else begin
          cnt_d = cnt + 8'd1;
        end
      end
      PRESENT: begin
        if (out_ready) begin
          // a code settling in the accept cycle is re-evaluated next cycle
          state_d = settled_c ? SETTLE : IDLE;
        end else if (settled_c) begin
          overrun_d = 1'b1;
          last_d    = cand;
        end else if (sync_b != cand) begin
          cand_d = sync_b;
          cnt_d  = '0;
        end else if (cnt != CNT_MAX) begin
          cnt_d = cnt + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      cand      <= RST_CODE;
      last_code <= RST_CODE;
      value     <= '0;
      out_valid <= 1'b0;
      error     <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      cand      <= cand_d;
      last_code <= last_d;
      value     <= value_d;
      out_valid <= (state_d == PRESENT);
      error     <= error_d;
      overrun   <= overrun_d;
    end
  end

`ifdef SEG2BIN_FINISH_EN
  // Finished flag follows each newly accepted valid value
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      finished <= 1'b0;
    end else if (load_c) begin
      finished <= (value_d == 7'd15);
    end
  end
`else
  assign finished = 1'b0;
`endif

endmodule
